// File: rtl/uart_byte_rx.sv
// UART byte receiver: 8N1 framing, 16x oversampling, majority vote at
// ticks 6/7/8 of every bit, selectable baud rate latched at the start edge.
// Outputs are registered; rx_done and frame_err are single-cycle pulses.
module uart_byte_rx #(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [2:0] set_baud,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       busy
);

    // Divider lengths (clocks per 16x tick) for each supported baud rate.
    localparam int N_9600   = CLK_HZ / (9600 * 16);
    localparam int N_19200  = CLK_HZ / (19200 * 16);
    localparam int N_38400  = CLK_HZ / (38400 * 16);
    localparam int N_57600  = CLK_HZ / (57600 * 16);
    localparam int N_115200 = CLK_HZ / (115200 * 16);

    // The slowest rate has the largest terminal count.
    localparam int DIV_W = $clog2(N_9600);

    localparam logic [DIV_W-1:0] TC_9600   = DIV_W'(N_9600 - 1);
    localparam logic [DIV_W-1:0] TC_19200  = DIV_W'(N_19200 - 1);
    localparam logic [DIV_W-1:0] TC_38400  = DIV_W'(N_38400 - 1);
    localparam logic [DIV_W-1:0] TC_57600  = DIV_W'(N_57600 - 1);
    localparam logic [DIV_W-1:0] TC_115200 = DIV_W'(N_115200 - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic             rx_s1;
    logic             rx_cur;
    logic             rx_prev;
    logic [2:0]       baud_q;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_tc;
    logic [3:0]       tick_cnt;
    logic [2:0]       bit_cnt;
    logic [1:0]       samp;
    logic [7:0]       shift_reg;
    logic             tick;
    logic             fall;
    logic             maj;

    // Two-flop synchronizer on rx plus a third flop holding the previous value.
    // NOTE: sequential state always uses non-blocking (<=) so every flop
    // samples pre-edge values, exactly as the hardware does.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1   <= 1'b1;
            rx_cur  <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= rx;
            rx_cur  <= rx_s1;
            rx_prev <= rx_cur;
        end
    end

    // Terminal count of the tick divider for the baud rate of the current frame.
    // NOTE: the default assignment first keeps this block purely combinational
    // (no latch) whatever the case arms cover.
    always_comb begin
        div_tc = TC_9600;
        case (baud_q)
            3'd1:    div_tc = TC_19200;
            3'd2:    div_tc = TC_38400;
            3'd3:    div_tc = TC_57600;
            3'd4:    div_tc = TC_115200;
            default: div_tc = TC_9600;
        endcase
    end

    assign fall = rx_prev & ~rx_cur;
    assign tick = (state != IDLE) && (div_cnt == div_tc);
    // Majority of the samples taken at ticks 6 and 7 and the live one at tick 8.
    assign maj  = (samp[0] & samp[1]) | (samp[0] & rx_cur) | (samp[1] & rx_cur);

    // Receive FSM with divider, tick/bit counters, shifter and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            baud_q    <= 3'd0;
            div_cnt   <= '0;
            tick_cnt  <= 4'd0;
            bit_cnt   <= 3'd0;
            samp      <= 2'b00;
            shift_reg <= 8'h00;
            data_byte <= 8'h00;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_done   <= 1'b0;
            frame_err <= 1'b0;

            if (state == IDLE) begin
                // Divider parked at 0 so tick 0 of the start bit begins at the edge.
                div_cnt  <= '0;
                tick_cnt <= 4'd0;
                bit_cnt  <= 3'd0;
                if (fall) begin
                    state  <= START;
                    busy   <= 1'b1;
                    baud_q <= set_baud;
                end
            end else begin
                if (div_cnt == div_tc) begin
                    div_cnt <= '0;
                end else begin
                    div_cnt <= div_cnt + 1'b1;
                end

                if (tick) begin
                    tick_cnt <= tick_cnt + 4'd1;
                    if (tick_cnt == 4'd6) begin
                        samp[0] <= rx_cur;
                    end
                    if (tick_cnt == 4'd7) begin
                        samp[1] <= rx_cur;
                    end

                    case (state)
                        START: begin
                            if (tick_cnt == 4'd8 && maj) begin
                                // Line back high mid start bit: noise, not a frame.
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else if (tick_cnt == 4'd15) begin
                                state   <= DATA;
                                bit_cnt <= 3'd0;
                            end
                        end
                        DATA: begin
                            if (tick_cnt == 4'd8) begin
                                shift_reg <= {maj, shift_reg[7:1]};
                            end
                            if (tick_cnt == 4'd15) begin
                                if (bit_cnt == 3'd7) begin
                                    state <= STOP;
                                end else begin
                                    bit_cnt <= bit_cnt + 3'd1;
                                end
                            end
                        end
                        STOP: begin
                            // Leave mid stop bit so a start edge right after it is caught.
                            if (tick_cnt == 4'd8) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                if (maj) begin
                                    data_byte <= shift_reg;
                                    rx_done   <= 1'b1;
                                end else begin
                                    frame_err <= 1'b1;
                                end
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Self-checking bench for uart_byte_rx: serial frames are generated at the
// nominal baud rates of a 50 MHz system; expected bytes go into a scoreboard
// queue and are popped whenever the receiver pulses rx_done.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] set_baud = 3'd0;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       busy;

    uart_byte_rx #(.CLK_HZ(50_000_000)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .set_baud  (set_baud),
        .data_byte (data_byte),
        .rx_done   (rx_done),
        .frame_err (frame_err),
        .busy      (busy)
    );

    // 50 MHz clock.
    always #10 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         ferr_cnt = 0;
    int         done_cyc = 0;
    int         start_cyc = 0;
    bit         busy_seen = 1'b0;
    bit         prev_done = 1'b0;
    bit         prev_ferr = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] exp_byte;

    always @(posedge clk) cyc++;

    // Output monitor: scoreboard pop on rx_done plus pulse-shape checks.
    always @(negedge clk) begin
        if (rst_n) begin
            if (busy) busy_seen = 1'b1;
            if (rx_done) begin
                done_cnt++;
                done_cyc = cyc;
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL scoreboard: unexpected rx_done, data_byte=%02h, no byte pending", data_byte);
                end else begin
                    exp_byte = exp_q.pop_front();
                    if (data_byte !== exp_byte) begin
                        bad++;
                        $display("FAIL scoreboard: data_byte=%02h expected %02h", data_byte, exp_byte);
                    end
                end
                total++;
                if (frame_err !== 1'b0 || prev_done) begin
                    bad++;
                    $display("FAIL done_pulse: frame_err=%b prev_done=%b, expected 0/0", frame_err, prev_done);
                end
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL busy_at_done: busy=%b expected 0", busy);
                end
            end
            if (frame_err) begin
                ferr_cnt++;
                total++;
                if (prev_ferr || busy !== 1'b0) begin
                    bad++;
                    $display("FAIL ferr_pulse: prev_ferr=%b busy=%b, expected 0/0", prev_ferr, busy);
                end
            end
        end
        prev_done = rx_done;
        prev_ferr = frame_err;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic v, input int n);
        rx = v;
        wait_clks(n);
    endtask

    // One 8N1 frame; set_baud is switched to mid_baud after the start bit.
    task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_clks,
                              input int stop_clks, input logic [2:0] mid_baud);
        start_cyc = cyc;
        drive_bit(1'b0, bit_clks);
        set_baud = mid_baud;
        for (int i = 0; i < 8; i++) drive_bit(b[i], bit_clks);
        drive_bit(stop, stop_clks);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < 16; i++) begin
            rx = i[0];
            @(negedge clk);
            total++;
            if ({data_byte, rx_done, frame_err, busy} !== 11'h000) begin
                bad++;
                $display("FAIL reset_hold: data=%02h done=%b ferr=%b busy=%b, expected 00/0/0/0",
                         data_byte, rx_done, frame_err, busy);
            end
        end
        rx = 1'b1;
        wait_clks(4);
        rst_n = 1'b1;
        wait_clks(20);
        total++;
        if (busy !== 1'b0 || done_cnt != 0 || ferr_cnt != 0) begin
            bad++;
            $display("FAIL reset_release: busy=%b done=%0d ferr=%0d, expected 0/0/0", busy, done_cnt, ferr_cnt);
        end
    endtask

    task automatic test_receive();
        int d0, f0, lat;
        d0 = done_cnt;
        f0 = ferr_cnt;
        set_baud = 3'd4;
        exp_q.push_back(8'hA5);
        send_frame(8'hA5, 1'b1, 434, 434, 3'd4);
        wait_clks(50);
        total++;
        if (done_cnt - d0 != 1 || ferr_cnt != f0) begin
            bad++;
            $display("FAIL rx_a5_count: done=%0d ferr=%0d, expected 1/0", done_cnt - d0, ferr_cnt - f0);
        end
        lat = done_cyc - start_cyc;
        total++;
        if (lat < 4093 || lat > 4153) begin
            bad++;
            $display("FAIL rx_a5_latency: %0d clk, expected 4093..4153", lat);
        end
        total++;
        if (data_byte !== 8'hA5) begin
            bad++;
            $display("FAIL rx_a5_data: %02h expected a5", data_byte);
        end
    endtask

    task automatic test_glitch();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        set_baud = 3'd4;
        busy_seen = 1'b0;
        drive_bit(1'b0, 100);
        drive_bit(1'b1, 600);
        total++;
        if (busy_seen !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL glitch_busy: seen=%b now=%b, expected 1/0", busy_seen, busy);
        end
        total++;
        if (done_cnt != d0 || ferr_cnt != f0 || data_byte !== 8'hA5) begin
            bad++;
            $display("FAIL glitch_quiet: done=%0d ferr=%0d data=%02h, expected 0/0/a5",
                     done_cnt - d0, ferr_cnt - f0, data_byte);
        end
    endtask

    task automatic test_frame_err();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        set_baud = 3'd0;
        // Baud select changes mid-frame; the latched 9600 must stay in force.
        send_frame(8'h3C, 1'b0, 5208, 3906, 3'd4);
        drive_bit(1'b1, 200);
        total++;
        if (ferr_cnt - f0 != 1 || done_cnt != d0) begin
            bad++;
            $display("FAIL ferr_count: ferr=%0d done=%0d, expected 1/0", ferr_cnt - f0, done_cnt - d0);
        end
        total++;
        if (data_byte !== 8'hA5) begin
            bad++;
            $display("FAIL ferr_data: %02h expected a5", data_byte);
        end
    endtask

    task automatic test_back_to_back();
        int d0, f0;
        d0 = done_cnt;
        f0 = ferr_cnt;
        set_baud = 3'd2;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(8'h00, 1'b1, 1302, 1302, 3'd2);
        send_frame(8'hFF, 1'b1, 1302, 1302, 3'd2);
        drive_bit(1'b1, 200);
        total++;
        if (done_cnt - d0 != 2 || ferr_cnt != f0) begin
            bad++;
            $display("FAIL b2b_count: done=%0d ferr=%0d, expected 2/0", done_cnt - d0, ferr_cnt - f0);
        end
        total++;
        if (data_byte !== 8'hFF || exp_q.size() != 0) begin
            bad++;
            $display("FAIL b2b_data: %02h pending=%0d, expected ff/0", data_byte, exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        int d0, f0;
        logic [7:0] b;
        b = 8'h5A;
        set_baud = 3'd4;
        drive_bit(1'b0, 434);
        for (int i = 0; i < 4; i++) drive_bit(b[i], 434);
        rst_n = 1'b0;
        rx = 1'b1;
        wait_clks(5);
        rst_n = 1'b1;
        wait_clks(50);
        total++;
        if (busy !== 1'b0 || data_byte !== 8'h00) begin
            bad++;
            $display("FAIL midreset_state: busy=%b data=%02h, expected 0/00", busy, data_byte);
        end
        d0 = done_cnt;
        f0 = ferr_cnt;
        exp_q.push_back(8'h81);
        send_frame(8'h81, 1'b1, 434, 434, 3'd4);
        wait_clks(50);
        total++;
        if (done_cnt - d0 != 1 || ferr_cnt != f0 || data_byte !== 8'h81) begin
            bad++;
            $display("FAIL midreset_rx: done=%0d ferr=%0d data=%02h, expected 1/0/81",
                     done_cnt - d0, ferr_cnt - f0, data_byte);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL midreset_pending: %0d bytes left, expected 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_receive();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid_frame();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
